// File: rtl/led_stream_tx.sv
// LED strip transmitter: pixel FIFO feeding a clock/data serialiser, MSB first, then a latch gap.
// Define LED_FRAME_HDR_EN for a 32-bit zero start word, 8'hFF per-LED prefix and trailing clock pulses.
module led_stream_tx #(
    parameter int PIXEL_W    = 24,
    parameter int LED_NUM    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int WAIT_CNT   = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [PIXEL_W-1:0]          s_data,
    output logic                        s_ready,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        cko_o,
    output logic                        sdo
);
`ifdef LED_FRAME_HDR_EN
    localparam int HDR_W     = 8;
    localparam int PRE_BITS  = 32;
    localparam int POST_BITS = (LED_NUM + 1) / 2;
    localparam int NSEG      = LED_NUM + 2;
`else
    localparam int HDR_W     = 0;
    localparam int PRE_BITS  = 0;
    localparam int POST_BITS = 0;
    localparam int NSEG      = LED_NUM;
`endif
    localparam int WORD_W  = PIXEL_W + HDR_W;
    localparam int MAX_A   = (WORD_W > PRE_BITS) ? WORD_W : PRE_BITS;
    localparam int MAX_LEN = (MAX_A > POST_BITS) ? MAX_A : POST_BITS;
    localparam int BIT_W   = $clog2(MAX_LEN + 1);
    localparam int SEG_W   = $clog2(NSEG + 1);
    localparam int PH_W    = $clog2(2 * CLK_DIV);
    localparam int GAP_W   = $clog2(WAIT_CNT + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(CLK_DIV - 1);
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NSEG - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(WAIT_CNT - 1);
    localparam logic [AW:0]      FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
    state_t state, state_nx;

    logic [PIXEL_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        level;
    logic               empty, full, push, pop, under;

    logic [WORD_W-1:0]  shreg, sh_next, ld_word;
    logic [PIXEL_W-1:0] pix;
    logic               fill, ld_fill, ld, ld_pix, seg_end;
    logic [PH_W-1:0]    phase;
    logic [BIT_W-1:0]   bit_cnt, seg_top, ld_top;
    logic [SEG_W-1:0]   seg, ld_seg;
    logic [GAP_W-1:0]   gap_cnt;

    assign empty      = (level == '0);
    assign full       = (level == FULL_LVL);
    assign pop        = ld_pix && !empty;
    assign under      = ld_pix && empty;
    // A pop frees a slot in the same cycle, so a full FIFO still takes a push while being drained.
    assign s_ready    = !full || pop;
    assign push       = s_valid && s_ready;
    assign fifo_level = level;
    assign busy       = (state != IDLE) || done;
    assign seg_end    = (state == SHIFT) && (phase == PH_LAST) && (bit_cnt == seg_top);
    assign sh_next    = (shreg << 1) | WORD_W'(fill);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        ld_seg   = seg + SEG_W'(1);
        case (state)
            IDLE:  if (start) state_nx = LOAD;
            LOAD:  begin
                ld       = 1'b1;
                ld_seg   = '0;
                state_nx = SHIFT;
            end
            SHIFT: if (seg_end) begin
                if (seg == SEG_LAST) state_nx = GAP;
                else                 ld = 1'b1;
            end
            GAP:   if (gap_cnt == GAP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Segment to load next: start word / pixel / trailer in header mode, pixels only otherwise.
    always_comb begin
        pix = empty ? '0 : mem[rd_ptr];
`ifdef LED_FRAME_HDR_EN
        ld_pix  = ld && (ld_seg != '0) && (ld_seg != SEG_LAST);
        ld_word = {8'hFF, pix};
        ld_top  = BIT_W'(WORD_W - 1);
        ld_fill = 1'b0;
        if (ld_seg == '0) begin
            ld_word = '0;
            ld_top  = BIT_W'(PRE_BITS - 1);
        end else if (ld_seg == SEG_LAST) begin
            ld_word = '1;
            ld_top  = BIT_W'(POST_BITS - 1);
            ld_fill = 1'b1;
        end
`else
        ld_pix  = ld;
        ld_word = pix;
        ld_top  = BIT_W'(WORD_W - 1);
        ld_fill = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            fill     <= 1'b0;
            phase    <= '0;
            bit_cnt  <= '0;
            seg_top  <= '0;
            seg      <= '0;
            gap_cnt  <= '0;
            cko_o    <= 1'b0;
            sdo      <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (ld) begin
                shreg   <= ld_word;
                fill    <= ld_fill;
                sdo     <= ld_word[WORD_W-1];
                cko_o   <= 1'b0;
                phase   <= '0;
                bit_cnt <= '0;
                seg_top <= ld_top;
                seg     <= ld_seg;
            end else if (state == SHIFT) begin
                if (phase == PH_LAST) begin
                    phase <= '0;
                    cko_o <= 1'b0;
                    if (seg_end) begin
                        sdo <= 1'b0;
                    end else begin
                        shreg   <= sh_next;
                        sdo     <= sh_next[WORD_W-1];
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end else begin
                    phase <= phase + PH_W'(1);
                    if (phase == PH_RISE) cko_o <= 1'b1;
                end
            end

            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            done    <= (state == GAP) && (gap_cnt == GAP_LAST);

            if (state == IDLE && start) underrun <= 1'b0;
            else if (under)             underrun <= 1'b1;
        end
    end
endmodule
